// File: rtl/sbg_pkg.sv
// Shared types and codes for the Simple Baseball Game pipeline.
// Holds PA result codes, winner codes, scoreboard FSM states and count-stage XY codes.
package sbg_pkg;

  localparam logic [1:0] PA_HIT  = 2'b00;
  localparam logic [1:0] PA_OUT  = 2'b01;
  localparam logic [1:0] PA_WALK = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_AWAY = 2'b01;
  localparam logic [1:0] WIN_HOME = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam logic [1:0] XY_IDLE = 2'b00;
  localparam logic [1:0] XY_X    = 2'b01;
  localparam logic [1:0] XY_Y    = 2'b10;
  localparam logic [1:0] XY_Z    = 2'b11;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } sb_state_t;

  function automatic logic [6:0] sat_inc(
    input logic [6:0] v,
    input logic [6:0] max
  );
    return (v < max) ? v + 7'd1 : v;
  endfunction

endpackage

// File: rtl/sbg_base_adv.sv
// Combinational base advance for one plate appearance.
// Ports: bases/result in; next_bases and run (one run scored) out.
module sbg_base_adv
  import sbg_pkg::*;
(
  input  logic [2:0] bases,
  input  logic [1:0] result,
  output logic [2:0] next_bases,
  output logic       run
);

  always_comb begin
    next_bases = bases;
    run        = 1'b0;
    case (result)
      PA_HIT: begin
        run        = bases[2];
        next_bases = {bases[1:0], 1'b1};
      end
      PA_WALK: begin
        // Forced advance: fill the lowest empty base.
        if (!bases[0])      next_bases[0] = 1'b1;
        else if (!bases[1]) next_bases[1] = 1'b1;
        else if (!bases[2]) next_bases[2] = 1'b1;
        else                run = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sbg_scoreboard.sv
// Game-level scoreboard: bases, runs, inning/half and end of game.
// Ports: clk, rst, pa_valid/pa_result, side_retire in; registered score/inning/half/bases/run_pulse/game_over/winner out.
module sbg_scoreboard
  import sbg_pkg::*;
#(
  parameter int NUM_INNINGS = 3,
  parameter int MAX_INNINGS = 9,
  parameter int SCORE_MAX   = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pa_valid,
  input  logic [1:0] pa_result,
  input  logic       side_retire,
  output logic [6:0] score_away,
  output logic [6:0] score_home,
  output logic [3:0] inning,
  output logic       half,
  output logic [2:0] bases,
  output logic       run_pulse,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [3:0] NUM_I = 4'(NUM_INNINGS);
  localparam logic [3:0] MAX_I = 4'(MAX_INNINGS);
  localparam logic [6:0] S_MAX = 7'(SCORE_MAX);

  sb_state_t  state_q, state_d;
  logic [6:0] away_d, home_d;
  logic [3:0] inning_d;
  logic       half_d, run_d;
  logic [2:0] bases_d, adv_bases;
  logic [1:0] winner_d;
  logic       adv_run;

  sbg_base_adv u_adv (
    .bases      (bases),
    .result     (pa_result),
    .next_bases (adv_bases),
    .run        (adv_run)
  );

  always_comb begin
    state_d  = state_q;
    away_d   = score_away;
    home_d   = score_home;
    inning_d = inning;
    half_d   = half;
    bases_d  = bases;
    run_d    = 1'b0;
    winner_d = winner;
    if (state_q == PLAY) begin
      if (side_retire) begin
        bases_d = '0;
        if (!half) begin
          if (inning >= NUM_I && score_home > score_away) begin
            state_d  = OVER;
            winner_d = WIN_HOME;
          end else begin
            half_d = 1'b1;
          end
        end else if (inning >= NUM_I && score_home != score_away) begin
          state_d  = OVER;
          winner_d = (score_home > score_away) ? WIN_HOME : WIN_AWAY;
        end else if (inning >= MAX_I) begin
          // Reaching here past regulation means the scores are level.
          state_d  = OVER;
          winner_d = WIN_TIE;
        end else begin
          half_d   = 1'b0;
          inning_d = inning + 4'd1;
        end
      end else if (pa_valid) begin
        bases_d = adv_bases;
        if (adv_run) begin
          run_d = 1'b1;
          if (half) home_d = sat_inc(score_home, S_MAX);
          else      away_d = sat_inc(score_away, S_MAX);
          // Walk-off: the go-ahead run in a deciding bottom half ends it.
          if (half && inning >= NUM_I && home_d > score_away) begin
            state_d  = OVER;
            winner_d = WIN_HOME;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PLAY;
      score_away <= '0;
      score_home <= '0;
      inning     <= 4'd1;
      half       <= 1'b0;
      bases      <= '0;
      run_pulse  <= 1'b0;
      winner     <= WIN_NONE;
    end else begin
      state_q    <= state_d;
      score_away <= away_d;
      score_home <= home_d;
      inning     <= inning_d;
      half       <= half_d;
      bases      <= bases_d;
      run_pulse  <= run_d;
      winner     <= winner_d;
    end
  end

  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_sbg_scoreboard.sv
// Directed self-checking bench for sbg_scoreboard.
// Runs with NUM_INNINGS=3 and MAX_INNINGS=4 so extra innings are reachable.
module tb_sbg_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pa_valid = 1'b0;
  logic [1:0] pa_result = 2'b00;
  logic       side_retire = 1'b0;
  logic [6:0] score_away, score_home;
  logic [3:0] inning;
  logic       half, run_pulse, game_over;
  logic [2:0] bases;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  sbg_scoreboard #(
    .NUM_INNINGS (3),
    .MAX_INNINGS (4),
    .SCORE_MAX   (99)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pa_valid    (pa_valid),
    .pa_result   (pa_result),
    .side_retire (side_retire),
    .score_away  (score_away),
    .score_home  (score_home),
    .inning      (inning),
    .half        (half),
    .bases       (bases),
    .run_pulse   (run_pulse),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ev(input logic v, input logic [1:0] r,
                    input logic s, input logic rr = 1'b0);
    @(negedge clk);
    pa_valid    = v;
    pa_result   = r;
    side_retire = s;
    rst         = rr;
    @(posedge clk);
    #1;
    pa_valid    = 1'b0;
    side_retire = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic hit();
    ev(1'b1, 2'b00, 1'b0);
  endtask

  task automatic walk();
    ev(1'b1, 2'b10, 1'b0);
  endtask

  task automatic retire();
    ev(1'b0, 2'b00, 1'b1);
  endtask

  task automatic do_reset();
    ev(1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".away"},  {1'b0, score_away}, 8'd0);
    chk({tag, ".home"},  {1'b0, score_home}, 8'd0);
    chk({tag, ".inn"},   {4'd0, inning}, 8'd1);
    chk({tag, ".half"},  {7'd0, half}, 8'd0);
    chk({tag, ".bases"}, {5'd0, bases}, 8'd0);
    chk({tag, ".rp"},    {7'd0, run_pulse}, 8'd0);
    chk({tag, ".go"},    {7'd0, game_over}, 8'd0);
    chk({tag, ".win"},   {6'd0, winner}, 8'd0);
  endtask

  initial begin
    do_reset();
    do_reset();
    chk_reset("rst0");

    hit();  chk("h1.bases", {5'd0, bases}, 8'h1);
    hit();  chk("h2.bases", {5'd0, bases}, 8'h3);
    chk("h2.rp", {7'd0, run_pulse}, 8'd0);
    hit();  chk("h3.bases", {5'd0, bases}, 8'h7);
    hit();
    chk("h4.away", {1'b0, score_away}, 8'd1);
    chk("h4.rp", {7'd0, run_pulse}, 8'd1);
    chk("h4.bases", {5'd0, bases}, 8'h7);
    ev(1'b0, 2'b00, 1'b0);
    chk("h4.rp_drop", {7'd0, run_pulse}, 8'd0);

    retire();
    chk("r1.half", {7'd0, half}, 8'd1);
    chk("r1.bases", {5'd0, bases}, 8'h0);
    hit(); hit();
    chk("b1.bases", {5'd0, bases}, 8'h3);
    ev(1'b1, 2'b01, 1'b0);
    chk("out.bases", {5'd0, bases}, 8'h3);
    ev(1'b1, 2'b11, 1'b0);
    chk("rsv.bases", {5'd0, bases}, 8'h3);
    walk();
    chk("w1.bases", {5'd0, bases}, 8'h7);
    chk("w1.rp", {7'd0, run_pulse}, 8'd0);
    chk("w1.home", {1'b0, score_home}, 8'd0);
    walk();
    chk("w2.bases", {5'd0, bases}, 8'h7);
    chk("w2.rp", {7'd0, run_pulse}, 8'd1);
    chk("w2.home", {1'b0, score_home}, 8'd1);

    retire();
    chk("r2.inn", {4'd0, inning}, 8'd2);
    chk("r2.half", {7'd0, half}, 8'd0);
    hit(); hit(); hit(); hit();
    chk("t2.away", {1'b0, score_away}, 8'd2);
    retire(); retire();
    chk("r4.inn", {4'd0, inning}, 8'd3);
    chk("r4.go", {7'd0, game_over}, 8'd0);
    retire();
    chk("t3.go", {7'd0, game_over}, 8'd0);
    chk("t3.half", {7'd0, half}, 8'd1);
    hit(); hit(); hit(); hit();
    chk("tie.home", {1'b0, score_home}, 8'd2);
    chk("tie.go", {7'd0, game_over}, 8'd0);
    hit();
    chk("wo.home", {1'b0, score_home}, 8'd3);
    chk("wo.go", {7'd0, game_over}, 8'd1);
    chk("wo.win", {6'd0, winner}, 8'h2);
    chk("wo.rp", {7'd0, run_pulse}, 8'd1);
    chk("wo.bases", {5'd0, bases}, 8'h7);

    hit();
    chk("ovr.home", {1'b0, score_home}, 8'd3);
    chk("ovr.rp", {7'd0, run_pulse}, 8'd0);
    chk("ovr.go", {7'd0, game_over}, 8'd1);
    ev(1'b1, 2'b00, 1'b0, 1'b1);
    chk_reset("rst1");

    // Tied game into extra innings.
    for (int i = 0; i < 6; i++) retire();
    chk("x4.inn", {4'd0, inning}, 8'd4);
    chk("x4.half", {7'd0, half}, 8'd0);
    chk("x4.go", {7'd0, game_over}, 8'd0);
    retire();
    chk("x4t.half", {7'd0, half}, 8'd1);
    retire();
    chk("x4b.go", {7'd0, game_over}, 8'd1);
    chk("x4b.win", {6'd0, winner}, 8'h3);
    chk("x4b.inn", {4'd0, inning}, 8'd4);

    // PA and side_retire together: retire wins.
    do_reset();
    hit(); hit(); hit();
    ev(1'b1, 2'b00, 1'b1);
    chk("sim.rp", {7'd0, run_pulse}, 8'd0);
    chk("sim.away", {1'b0, score_away}, 8'd0);
    chk("sim.bases", {5'd0, bases}, 8'h0);
    chk("sim.half", {7'd0, half}, 8'd1);

    // Saturation of the away score.
    do_reset();
    hit(); hit(); hit();
    for (int i = 0; i < 99; i++) walk();
    chk("sat99.away", {1'b0, score_away}, 8'd99);
    walk();
    chk("sat.away", {1'b0, score_away}, 8'd99);
    chk("sat.rp", {7'd0, run_pulse}, 8'd1);
    chk("sat.go", {7'd0, game_over}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
